avg_seq_ctrl: RTL and testbench

- Sequencer for the range-gate moving-average datapath in the DME receive chain.
- Gates the incoming sample stream into the averager and issues a clean clear on every acquisition start.
- Tracks window fill, suppresses averages until the window is full, then decimates averager output to one result per DECIM samples.
- Presents results on a valid/ready port and counts results dropped by downstream backpressure.

---
 rtl/avg_ctrl_pkg.sv | 16 +
 rtl/avg_result_slot.sv | 54 +++++
 rtl/avg_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_avg_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_ctrl_pkg.sv
// Shared state encoding and pipeline constants for the moving-average sequencer.
// No logic, no latency, no backpressure.
package avg_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_FILL  = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   // Edges from the accepting edge to the edge that samples dp_avg.
   localparam int CAP_LAT    = 3;
   localparam int DEF_DROP_W = 8;

endpackage

// File: rtl/avg_result_slot.sv
// One-entry result register with valid/ready and a saturating count of lost results.
// Loads on the load edge; when full and not drained, a new load is dropped and counted.
module avg_result_slot #(
   parameter int WIDTH  = 24,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_dat,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [WIDTH-1:0]  m_data,
   output logic [DROP_W-1:0] drop_cnt
);

   logic              vld_q, vld_d;
   logic [WIDTH-1:0]  dat_q, dat_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      drop_d = drop_q;
      if (load) begin
         // A draining slot takes the new result in the same edge it hands off the old one.
         if (!vld_q || m_ready) begin
            vld_d = 1'b1;
            dat_d = load_dat;
         end else if (drop_q != {DROP_W{1'b1}}) begin
            drop_d = drop_q + 1'b1;
         end
      end else if (vld_q && m_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_q  <= 1'b0;
         dat_q  <= '0;
         drop_q <= '0;
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         drop_q <= drop_d;
      end
   end

   assign m_valid  = vld_q;
   assign m_data   = dat_q;
   assign drop_cnt = drop_q;

endmodule

// File: rtl/avg_seq_ctrl.sv
// Sequencer for the range-gate averager: gates samples in, clears on start, decimates results.
// Feed reaches dp_en two edges after accept, result three; results lost to backpressure are counted.
module avg_seq_ctrl
   import avg_ctrl_pkg::*;
#(
   parameter int WIDTH  = 24,
   parameter int N      = 128,
   parameter int DECIM  = 16,
   parameter int DROP_W = DEF_DROP_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic              s_valid,
   input  logic [WIDTH-1:0]  s_data,
   output logic              s_ready,
   output logic              dp_en,
   output logic [WIDTH-1:0]  dp_data,
   output logic              dp_clr,
   input  logic [WIDTH-1:0]  dp_avg,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WIDTH-1:0]  m_data,
   output logic [1:0]        state,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int FW = $clog2(N) + 1;
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
   localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);

   state_e             state_q, state_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic [DW-1:0]      dec_q, dec_d;
   logic [CAP_LAT-1:0] cap_q, cap_d;
   logic               feed_vld_q, feed_vld_d;
   logic [WIDTH-1:0]   feed_dat_q, feed_dat_d;
   logic               dp_en_q, dp_en_d;
   logic [WIDTH-1:0]   dp_data_q, dp_data_d;
   logic               acc, cap_now, restart;

   assign s_ready = (state_q == ST_FILL) || (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      dec_d   = dec_q;
      cap_now = 1'b0;
      acc     = s_valid && s_ready;
      restart = start && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: state_d = state_q;
         ST_CLEAR: begin
            fill_d  = '0;
            dec_d   = '0;
            state_d = ST_FILL;
         end
         ST_FILL: if (acc) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == FILL_LAST) begin
               cap_now = 1'b1;
               dec_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: if (acc) begin
            if (dec_q == DEC_LAST) begin
               dec_d   = '0;
               cap_now = 1'b1;
            end else begin
               dec_d = dec_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (start) begin
         state_d = ST_CLEAR;
      end else if (stop && ((state_q == ST_FILL) || (state_q == ST_RUN))) begin
         state_d = ST_IDLE;
      end
      // A restart invalidates captures still travelling towards the old window's average.
      cap_d      = restart ? '0 : {cap_q[CAP_LAT-2:0], cap_now};
      feed_vld_d = acc;
      feed_dat_d = acc ? s_data : feed_dat_q;
      dp_en_d    = feed_vld_q;
      dp_data_d  = feed_vld_q ? feed_dat_q : dp_data_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         fill_q     <= '0;
         dec_q      <= '0;
         cap_q      <= '0;
         feed_vld_q <= 1'b0;
         feed_dat_q <= '0;
         dp_en_q    <= 1'b0;
         dp_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         dec_q      <= dec_d;
         cap_q      <= cap_d;
         feed_vld_q <= feed_vld_d;
         feed_dat_q <= feed_dat_d;
         dp_en_q    <= dp_en_d;
         dp_data_q  <= dp_data_d;
      end
   end

   assign dp_clr  = (state_q == ST_CLEAR);
   assign dp_en   = dp_en_q;
   assign dp_data = dp_data_q;
   assign state   = state_q;

   avg_result_slot #(
      .WIDTH  (WIDTH),
      .DROP_W (DROP_W)
   ) u_slot (
      .clk      (clk),
      .resetn   (resetn),
      .load     (cap_q[CAP_LAT-1]),
      .load_dat (dp_avg),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .drop_cnt (drop_cnt)
   );

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Bench for avg_seq_ctrl with N=4, DECIM=2, DROP_W=2 and a true 4-sample-mean datapath.
// Reference tracks accepted samples per acquisition and predicts every result from window means.
module tb_avg_seq_ctrl;

   localparam int WIDTH    = 24;
   localparam int N        = 4;
   localparam int DECIM    = 2;
   localparam int DROP_W   = 2;
   localparam int DROP_MAX = 3;

   logic              clk, resetn, start, stop, s_valid, s_ready;
   logic              dp_en, dp_clr, m_valid, m_ready;
   logic [WIDTH-1:0]  s_data, dp_data, dp_avg, m_data;
   logic [1:0]        state;
   logic [DROP_W-1:0] drop_cnt;

   typedef struct {
      int               due;
      logic [WIDTH-1:0] val;
   } cap_t;

   cap_t             capq[$];
   logic [WIDTH-1:0] win[$];
   logic [WIDTH-1:0] feedq[$];
   int               phase;   // 0 idle, 1 clearing, 2 acquiring
   int               cnt, ecnt, e_drop, acc_total, dp_seen, clr_seen, quiet;
   bit               e_vld;
   logic [WIDTH-1:0] e_dat;
   int               n_cmp = 0;
   int               n_bad = 0;

   avg_seq_ctrl #(
      .WIDTH (WIDTH), .N (N), .DECIM (DECIM), .DROP_W (DROP_W)
   ) dut (
      .clk (clk), .resetn (resetn), .start (start), .stop (stop),
      .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
      .dp_en (dp_en), .dp_data (dp_data), .dp_clr (dp_clr), .dp_avg (dp_avg),
      .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
      .state (state), .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stand-in: registered mean of the last N consumed samples.
   logic [WIDTH-1:0] h0, h1, h2;
   always @(posedge clk or negedge resetn) begin
      if (!resetn || dp_clr) begin
         h0 <= '0; h1 <= '0; h2 <= '0; dp_avg <= '0;
      end else if (dp_en) begin
         h0 <= dp_data; h1 <= h0; h2 <= h1;
         dp_avg <= 24'((26'(dp_data) + 26'(h0) + 26'(h1) + 26'(h2)) >> 2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_state();
      if (phase == 0) return 0;
      if (phase == 1) return 1;
      return (cnt < N) ? 2 : 3;
   endfunction

   task automatic model_edge(input bit st, input bit sp, input bit sv,
                             input logic [WIDTH-1:0] sd, input bit mr);
      int   s;
      cap_t c;
      ecnt++;
      if (sv && phase == 2) begin
         acc_total++;
         feedq.push_back(sd);
         win.push_back(sd);
         if (win.size() > N) void'(win.pop_front());
         cnt++;
         if (cnt >= N && (cnt - N) % DECIM == 0) begin
            s = 0;
            foreach (win[i]) s += int'(win[i]);
            c.due = ecnt + 3;
            c.val = 24'(s / N);
            capq.push_back(c);
         end
      end
      if (capq.size() > 0 && capq[0].due == ecnt) begin
         c = capq.pop_front();
         if (!e_vld || mr) begin
            e_vld = 1'b1;
            e_dat = c.val;
         end else if (e_drop < DROP_MAX) begin
            e_drop++;
         end
      end else if (e_vld && mr) begin
         e_vld = 1'b0;
      end
      if (st) begin
         if (phase != 0) capq.delete();
         phase = 1;
         cnt   = 0;
         win.delete();
      end else if (sp && phase == 2) begin
         phase = 0;
      end else if (phase == 1) begin
         phase = 2;
      end
   endtask

   task automatic check_outputs();
      chk("state", 32'(state), exp_state());
      chk("s_ready", 32'(s_ready), 32'(phase == 2));
      chk("dp_clr", 32'(dp_clr), 32'(phase == 1));
      chk("m_valid", 32'(m_valid), 32'(e_vld));
      if (e_vld) chk("m_data", 32'(m_data), 32'(e_dat));
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
      if (dp_clr) clr_seen++;
      if (dp_en) begin
         dp_seen++;
         if (feedq.size() == 0) chk("dp_en_spurious", 32'(dp_en), 32'd0);
         else chk("dp_data", 32'(dp_data), 32'(feedq.pop_front()));
      end
   endtask

   task automatic step(input bit st, input bit sp, input bit sv,
                       input logic [WIDTH-1:0] sd, input bit mr);
      start = st; stop = sp; s_valid = sv; s_data = sd; m_ready = mr;
      quiet = sv ? 0 : quiet + 1;
      model_edge(st, sp, sv, sd, mr);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n, input bit mr);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, mr);
   endtask

   task automatic samp(input logic [WIDTH-1:0] d, input bit mr);
      step(1'b0, 1'b0, 1'b1, d, mr);
   endtask

   task automatic go(input bit mr);
      step(1'b1, 1'b0, 1'b0, '0, mr);
   endtask

   task automatic do_reset();
      #3;
      resetn = 1'b0;
      start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_dp_en", 32'(dp_en), 32'd0);
      chk("rst_dp_data", 32'(dp_data), 32'd0);
      chk("rst_dp_clr", 32'(dp_clr), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      phase = 0; cnt = 0; e_vld = 1'b0; e_drop = 0; e_dat = '0;
      capq.delete(); win.delete(); feedq.delete();
      dp_seen = 0; acc_total = 0; quiet = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      int  d0, c0;
      bit  st, sp, sv, mr, want_start;
      logic [WIDTH-1:0] sd;
      resetn = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      ecnt = 0; clr_seen = 0; want_start = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      idle(2, 1'b1);

      // First window: one result, mean 10, then decimated result 18.
      go(1'b1);
      idle(1, 1'b1);
      d0 = dp_seen;
      for (int i = 1; i <= 4; i++) samp(24'(4 * i), 1'b1);
      idle(5, 1'b1);
      chk("t1_dp_en_cnt", 32'(dp_seen - d0), 32'd4);
      chk("t1_state", 32'(state), 32'd3);
      samp(24'd20, 1'b1);
      samp(24'd24, 1'b1);
      idle(5, 1'b1);

      // Backpressure: the first result holds, later ones are counted as drops.
      do_reset();
      go(1'b0);
      idle(1, 1'b0);
      for (int i = 1; i <= 8; i++) samp(24'(4 * i), 1'b0);
      idle(4, 1'b0);
      chk("t4_m_data", 32'(m_data), 32'd10);
      chk("t4_drop", 32'(drop_cnt), 32'd2);
      chk("t4_m_valid", 32'(m_valid), 32'd1);
      idle(1, 1'b1);
      chk("t4_after_xfer", 32'(m_valid), 32'd0);
      idle(3, 1'b1);

      // Stop right after the window fills: the in-flight result still lands.
      go(1'b1);
      idle(1, 1'b1);
      for (int i = 1; i <= 4; i++) samp(24'(4 * i), 1'b1);
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
      chk("t5_state", 32'(state), 32'd0);
      chk("t5_s_ready", 32'(s_ready), 32'd0);
      idle(2, 1'b1);
      chk("t5_m_valid", 32'(m_valid), 32'd1);
      chk("t5_m_data", 32'(m_data), 32'd10);
      idle(4, 1'b1);

      // start and stop together in RUN restart the acquisition.
      go(1'b1);
      idle(1, 1'b1);
      for (int i = 1; i <= 4; i++) samp(24'(4 * i), 1'b1);
      idle(3, 1'b1);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1);
      chk("t6_state_clear", 32'(state), 32'd1);
      idle(1, 1'b1);
      chk("t6_state_fill", 32'(state), 32'd2);
      samp(24'd40, 1'b1); samp(24'd44, 1'b1); samp(24'd48, 1'b1);
      idle(4, 1'b1);
      chk("t6_no_result", 32'(m_valid), 32'd0);
      samp(24'd52, 1'b1);
      idle(4, 1'b1);
      for (int i = 0; i < 12; i++) samp(24'(100 + 8 * i), 1'b0);
      idle(4, 1'b0);
      chk("t6_drop_sat", 32'(drop_cnt), 32'd3);

      // Reset in RUN with a result pending, then one clean clear on the next start.
      do_reset();
      c0 = clr_seen;
      go(1'b1);
      idle(3, 1'b1);
      chk("t0_clr_cycles", 32'(clr_seen - c0), 32'd1);

      for (int i = 0; i < 2000; i++) begin
         sv = ($urandom_range(0, 9) < 7);
         mr = ($urandom_range(0, 9) < 6);
         sd = 24'($urandom_range(0, 24'hFFFFF));
         sp = ($urandom_range(0, 59) == 0);
         st = 1'b0;
         if ($urandom_range(0, 39) == 0) want_start = 1'b1;
         if (want_start) begin
            sv = 1'b0;
            if (quiet >= 3) begin
               st = 1'b1;
               want_start = 1'b0;
               sp = ($urandom_range(0, 3) == 0);
            end
         end
         step(st, sp, sv, sd, mr);
      end
      idle(8, 1'b1);
      chk("dp_en_count", 32'(dp_seen), 32'(acc_total));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
